// File: rtl/mul8_rr_scheduler.sv
// Round-robin scheduler sharing one 8x8 unsigned multiplier among NUM_REQ requesters,
// with a single-entry result buffer. Define MUL8_RR_SCHEDULER_STATS_EN for per-requester grant counters.

module traditional_multiplier8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   // Plain shift-and-add; fully combinational.
   always_comb begin
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p + (16'(a) << i);
      end
   end
endmodule

module mul8_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [8*NUM_REQ-1:0]   req_op1_i,
   input  logic [8*NUM_REQ-1:0]   req_op2_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic [15:0]            resp_product_o,
   output logic [ID_W-1:0]        resp_id_o
`ifdef MUL8_RR_SCHEDULER_STATS_EN
   ,
   input  logic                   stat_clr_i,
   output logic [16*NUM_REQ-1:0]  stat_grants_o
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_next;
   logic [NUM_REQ-1:0]   grant_oh;
   logic [ID_W-1:0]      grant_id;
   logic                 transfer;
   logic                 can_accept;
   int                   scan_idx;
   logic [7:0]           mul_a, mul_b;
   logic [15:0]          mul_p;

   // Handshakes: a beat moves on a rising edge when valid and ready are both high;
   // ready never looks at operands, and valid holds with stable data until ready.
   assign resp_valid_o = (state_q == FULL);
   assign can_accept   = (state_q == EMPTY) || (resp_valid_o && resp_ready_i);

   always_comb begin
      grant_oh = '0;
      grant_id = '0;
      transfer = 1'b0;
      scan_idx = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = int'(rr_ptr_q) + i;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (!transfer && req_valid_i[scan_idx]) begin
            transfer           = 1'b1;
            grant_oh[scan_idx] = 1'b1;
            grant_id           = ID_W'(scan_idx);
         end
      end
      if (rst_i || !can_accept) begin
         grant_oh = '0;
         transfer = 1'b0;
      end
   end

   assign req_ready_o = grant_oh;

   assign mul_a = req_op1_i[8*grant_id +: 8];
   assign mul_b = req_op2_i[8*grant_id +: 8];

   traditional_multiplier8 u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   always_comb begin
      if (grant_id == ID_W'(NUM_REQ - 1)) rr_next = '0;
      else                                 rr_next = grant_id + ID_W'(1);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (transfer) state_d = FULL;
         FULL:    if (!transfer && resp_ready_i) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= EMPTY;
         rr_ptr_q       <= '0;
         resp_product_o <= '0;
         resp_id_o      <= '0;
      end else begin
         state_q <= state_d;
         if (transfer) begin
            resp_product_o <= mul_p;
            resp_id_o      <= grant_id;
            rr_ptr_q       <= rr_next;
         end
      end
   end

`ifdef MUL8_RR_SCHEDULER_STATS_EN
   logic [15:0] grant_cnt_q [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
      // Clear wins over a same-cycle increment; counters stick at 0xFFFF.
      always_ff @(posedge clk_i) begin
         if (rst_i || stat_clr_i)
            grant_cnt_q[k] <= '0;
         else if (grant_oh[k] && grant_cnt_q[k] != 16'hFFFF)
            grant_cnt_q[k] <= grant_cnt_q[k] + 16'd1;
      end
      assign stat_grants_o[16*k +: 16] = grant_cnt_q[k];
   end
`endif

endmodule
